// File: rtl/adc_capture_packer.sv
// ADC sample packer: SAMPLES_PER_WORD samples plus OR/trigger status per FIFO word, with
// capture length, trigger arming, overflow and abort. Define DECIMATE_EN to add sample decimation.
module adc_capture_packer #(
    parameter int SAMPLE_W         = 10,
    parameter int SAMPLES_PER_WORD = 3,
    parameter int WORD_W           = 32,
    parameter int CNT_W            = 32
) (
    input  logic                adc_sampleclk,
    input  logic                ddr_usrreset,
    input  logic                capture_go,
    input  logic                trig_mode,
    input  logic [CNT_W-1:0]    capture_words,
    input  logic [SAMPLE_W-1:0] adc_datain,
    input  logic                adc_or,
    input  logic                adc_trig_status,
`ifdef DECIMATE_EN
    input  logic [7:0]          decimate,
`endif
    output logic [WORD_W-1:0]   fifo_din,
    output logic                fifo_wr_en,
    input  logic                fifo_full,
    output logic                capture_busy,
    output logic                capture_stop,
    output logic [CNT_W-1:0]    word_count,
    output logic                overflow
);
    localparam int DATA_W = SAMPLES_PER_WORD * SAMPLE_W;
    localparam int SLOT_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    len_q, offered_q, word_count_q;
    logic                overflow_q, or_acc_q, trig_prev_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [DATA_W-1:0]   data_q;
    logic [WORD_W-1:0]   fifo_din_q;
    logic                fifo_wr_en_q, busy_q, stop_q;
    logic [7:0]          dec_q;

    logic                trig_edge, dec_hit, active, store, last, final_word;
    logic [DATA_W-1:0]   samples_d;
    logic [WORD_W-1:0]   word_d;

    assign trig_edge = adc_trig_status & ~trig_prev_q;
`ifdef DECIMATE_EN
    assign dec_hit = (dec_q == 8'd0);
`else
    assign dec_hit = 1'b1;
`endif
    // active: this clock belongs to a word period (OR accumulation runs even on decimated-out clocks)
    assign active     = capture_go & ((state_q == CAPTURE) | ((state_q == ARMED) & trig_edge));
    assign store      = capture_go & (((state_q == CAPTURE) & dec_hit) | ((state_q == ARMED) & trig_edge));
    assign last       = store & (slot_q == SLOT_W'(SAMPLES_PER_WORD - 1));
    assign final_word = (offered_q + CNT_W'(1)) == len_q;

    always_comb begin
        samples_d = data_q;
        samples_d[slot_q*SAMPLE_W +: SAMPLE_W] = adc_datain;
        word_d = '0;
        word_d[DATA_W-1:0] = samples_d;
        word_d[WORD_W-1]   = or_acc_q | adc_or;
        word_d[WORD_W-2]   = adc_trig_status;
    end

    always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
        if (ddr_usrreset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            offered_q    <= '0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            or_acc_q     <= 1'b0;
            trig_prev_q  <= 1'b0;
            slot_q       <= '0;
            data_q       <= '0;
            fifo_din_q   <= '0;
            fifo_wr_en_q <= 1'b0;
            busy_q       <= 1'b0;
            stop_q       <= 1'b0;
            dec_q        <= '0;
        end else begin
            trig_prev_q  <= adc_trig_status;
            fifo_wr_en_q <= 1'b0;

            if (store) begin
                data_q <= samples_d;
                slot_q <= last ? '0 : slot_q + SLOT_W'(1);
            end
            if (active)
                or_acc_q <= last ? 1'b0 : (or_acc_q | adc_or);

            case (state_q)
                IDLE: if (capture_go) begin
                    len_q        <= capture_words;
                    offered_q    <= '0;
                    word_count_q <= '0;
                    overflow_q   <= 1'b0;
                    slot_q       <= '0;
                    or_acc_q     <= 1'b0;
                    dec_q        <= '0;
                    if (capture_words == '0) begin
                        state_q <= DONE;
                        stop_q  <= 1'b1;
                    end else begin
                        state_q <= trig_mode ? ARMED : CAPTURE;
                        busy_q  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!capture_go) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (trig_edge) begin
                        state_q <= CAPTURE;
`ifdef DECIMATE_EN
                        // trigger clock already consumed one decimation period
                        dec_q <= (decimate == 8'd0) ? 8'd0 : 8'd1;
`endif
                    end
                end
                CAPTURE: begin
                    if (!capture_go) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
`ifdef DECIMATE_EN
                    else
                        dec_q <= (dec_q == decimate) ? 8'd0 : dec_q + 8'd1;
`endif
                end
                DONE: if (!capture_go) begin
                    state_q <= IDLE;
                    stop_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    stop_q  <= 1'b0;
                end
            endcase

            // word completion overrides the state update above when it ends the capture
            if (last) begin
                offered_q <= offered_q + CNT_W'(1);
                if (fifo_full) begin
                    overflow_q <= 1'b1;
                end else begin
                    fifo_wr_en_q <= 1'b1;
                    fifo_din_q   <= word_d;
                    word_count_q <= word_count_q + CNT_W'(1);
                end
                if (final_word) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    stop_q  <= 1'b1;
                end
            end
        end
    end

    assign fifo_din     = fifo_din_q;
    assign fifo_wr_en   = fifo_wr_en_q;
    assign capture_busy = busy_q;
    assign capture_stop = stop_q;
    assign word_count   = word_count_q;
    assign overflow     = overflow_q;
endmodule
